// File: rtl/vend_pkg.sv
// Shared types, constants and helpers for the vending machine sequencer.
package vend_pkg;

  localparam int unsigned CreditWDefault = 8;
  localparam int unsigned StockW         = 4;
  localparam int unsigned TimerW         = 16;

  // Coin values in 10c units
  localparam logic [4:0] Coin10c  = 5'd1;
  localparam logic [4:0] Coin20c  = 5'd2;
  localparam logic [4:0] Coin50c  = 5'd5;
  localparam logic [4:0] Coin100c = 5'd10;

  typedef enum logic [1:0] {
    StIdle,
    StVend,
    StChange
  } vend_state_e;

  function automatic logic [4:0] coin_sum(input logic [3:0] coins);
    logic [4:0] sum;
    sum = '0;
    if (coins[0]) sum = sum + Coin10c;
    if (coins[1]) sum = sum + Coin20c;
    if (coins[2]) sum = sum + Coin50c;
    if (coins[3]) sum = sum + Coin100c;
    return sum;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; o_done is high whenever the count has reached zero.
module vend_timer
  import vend_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [TimerW-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_done
);

  logic [TimerW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credit accumulation, price/stock checks, dispense timing and change payout.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned                   NUM_ITEMS   = 4,
  parameter int unsigned                   CREDIT_W    = CreditWDefault,
  parameter int unsigned                   MAX_CREDIT  = 200,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE       = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int unsigned                   STOCK_INIT  = 5,
  parameter int unsigned                   DISP_CYCLES = 50,
  parameter int unsigned                   CHANGE_GAP  = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           coin_trig,
  input  logic [NUM_ITEMS-1:0] sel_trig,
  input  logic                 cancel_trig,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] dispense,
  output logic                 change_pulse,
  output logic                 busy,
  output logic                 coin_reject,
  output logic                 err_funds,
  output logic                 err_empty,
  output logic [NUM_ITEMS-1:0] sold_out
);

  localparam int unsigned       IdxW       = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam logic [CREDIT_W:0] MaxCredit  = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [StockW-1:0] StockInit  = StockW'(STOCK_INIT);
  localparam logic [TimerW-1:0] DispLoad   = TimerW'(DISP_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLoad    = TimerW'(CHANGE_GAP - 1);

  vend_state_e                          r_state, w_state_d;
  logic [CREDIT_W-1:0]                  r_credit, w_credit_d;
  logic [NUM_ITEMS-1:0][StockW-1:0]     r_stock, w_stock_d;
  logic [NUM_ITEMS-1:0]                 r_dispense, w_dispense_d;
  logic [NUM_ITEMS-1:0]                 r_sold_out, w_sold_out_d;
  logic                                 r_change, w_change_d;
  logic                                 r_reject, w_reject_d;
  logic                                 r_funds, w_funds_d;
  logic                                 r_empty, w_empty_d;
  logic                                 r_busy;

  logic                                 w_tmr_load, w_tmr_dec, w_tmr_done;
  logic [TimerW-1:0]                    w_tmr_val;
  logic [IdxW-1:0]                      w_sel_idx;
  logic [CREDIT_W-1:0]                  w_price;
  logic [CREDIT_W:0]                    w_credit_sum;
  logic                                 w_taken;

  vend_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_done     (w_tmr_done)
  );

  // Lowest set select bit wins: scan downwards so the lowest index is written last
  always_comb begin
    w_sel_idx = '0;
    w_price   = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (sel_trig[i]) begin
        w_sel_idx = IdxW'(i);
        w_price   = PRICE[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  assign w_credit_sum = {1'b0, r_credit} + (CREDIT_W+1)'(coin_sum(coin_trig));

  always_comb begin
    w_state_d    = r_state;
    w_credit_d   = r_credit;
    w_stock_d    = r_stock;
    w_dispense_d = r_dispense;
    w_change_d   = 1'b0;
    w_reject_d   = 1'b0;
    w_funds_d    = 1'b0;
    w_empty_d    = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_tmr_dec    = 1'b0;
    w_taken      = 1'b0;

    case (r_state)
      StIdle: begin
        if (cancel_trig && (r_credit != '0)) begin
          w_state_d  = StChange;
          w_tmr_load = 1'b1;
          w_taken    = 1'b1;
        end else if (|sel_trig) begin
          if (r_stock[w_sel_idx] == '0) begin
            w_empty_d = 1'b1;
          end else if (r_credit < w_price) begin
            w_funds_d = 1'b1;
          end else begin
            w_credit_d              = r_credit - w_price;
            w_stock_d[w_sel_idx]    = r_stock[w_sel_idx] - 1'b1;
            w_dispense_d            = '0;
            w_dispense_d[w_sel_idx] = 1'b1;
            w_state_d               = StVend;
            w_tmr_load              = 1'b1;
            w_tmr_val               = DispLoad;
            w_taken                 = 1'b1;
          end
        end
        // A cycle's coins are accepted or refused as a whole
        if (|coin_trig) begin
          if (w_taken || (w_credit_sum > MaxCredit)) begin
            w_reject_d = 1'b1;
          end else begin
            w_credit_d = w_credit_sum[CREDIT_W-1:0];
          end
        end
      end

      StVend: begin
        w_reject_d = |coin_trig;
        if (w_tmr_done) begin
          w_dispense_d = '0;
          if (r_credit != '0) begin
            w_state_d  = StChange;
            w_tmr_load = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      StChange: begin
        w_reject_d = |coin_trig;
        if (r_credit == '0) begin
          w_state_d = StIdle;
        end else if (w_tmr_done) begin
          w_change_d = 1'b1;
          w_credit_d = r_credit - 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = GapLoad;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      default: begin
        w_state_d    = StIdle;
        w_dispense_d = '0;
      end
    endcase

    for (int i = 0; i < NUM_ITEMS; i++) begin
      w_sold_out_d[i] = (w_stock_d[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_credit   <= '0;
      r_dispense <= '0;
      r_sold_out <= '0;
      r_change   <= 1'b0;
      r_reject   <= 1'b0;
      r_funds    <= 1'b0;
      r_empty    <= 1'b0;
      r_busy     <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        r_stock[i] <= StockInit;
      end
    end else begin
      r_state    <= w_state_d;
      r_credit   <= w_credit_d;
      r_stock    <= w_stock_d;
      r_dispense <= w_dispense_d;
      r_sold_out <= w_sold_out_d;
      r_change   <= w_change_d;
      r_reject   <= w_reject_d;
      r_funds    <= w_funds_d;
      r_empty    <= w_empty_d;
      r_busy     <= (w_state_d != StIdle);
    end
  end

  assign credit       = r_credit;
  assign dispense     = r_dispense;
  assign change_pulse = r_change;
  assign busy         = r_busy;
  assign coin_reject  = r_reject;
  assign err_funds    = r_funds;
  assign err_empty    = r_empty;
  assign sold_out     = r_sold_out;

endmodule
